// File: rtl/mem_access_timed_fifo.sv
// ---------------------------------------------------------------------------
// mem_access_timed_fifo
//
// Timed FIFO for pipeline memory accesses. Each pushed RAM address is stored
// with a push timestamp (in) and a release timestamp (out = in + delay). The
// head entry is presented as valid only once the free-running timebase
// count_i has advanced by at least the stored delay. The due test is
// wrap-safe. Ordering is strictly FIFO, so a non-due head blocks everything
// behind it.
//
// Optional feature (compile-time macro MEM_FIFO_ZERO_DELAY_BYPASS_EN):
//   When defined, a zero-delay push into an empty FIFO is presented at the
//   head in the same cycle. If it is popped in that cycle it is never
//   written. When the macro is undefined, an empty FIFO never shows valid_o.
//
// Parameters
//   ADDR_W   width of stored RAM address
//   DEPTH    number of entries (power of two, >= 2)
//   DELAY_W  width of per-entry delay (DELAY_W < TIME_W)
//   TIME_W   width of timebase and timestamps
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   stall_i          freezes push and pop
//   push_i           push request
//   addr_i           address to enqueue
//   delay_i          timebase cycles before the entry may leave
//   count_i          free-running timebase (wraps)
//   pop_i            consumer takes the head this cycle
//   addr_o           head address (0 while empty)
//   valid_o          head present and due
//   head_in_time_o   head push timestamp (0 while empty)
//   head_out_time_o  head release timestamp (0 while empty)
//   full_o           level == DEPTH
//   empty_o          level == 0
//   level_o          occupancy, 0..DEPTH
//   ovf_o            sticky: a push was dropped while full
// ---------------------------------------------------------------------------
module mem_access_timed_fifo #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 16,
  parameter int DELAY_W = 10,
  parameter int TIME_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_i,
  input  logic                       push_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DELAY_W-1:0]         delay_i,
  input  logic [TIME_W-1:0]          count_i,
  input  logic                       pop_i,
  output logic [ADDR_W-1:0]          addr_o,
  output logic                       valid_o,
  output logic [TIME_W-1:0]          head_in_time_o,
  output logic [TIME_W-1:0]          head_out_time_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Wrap-safe due test: both distances are measured from the push time, so
  // the comparison stays correct across timebase wrap as long as the delay
  // is shorter than half the timebase range.
  function automatic logic f_due(input logic [TIME_W-1:0] now,
                                 input logic [TIME_W-1:0] t_in,
                                 input logic [TIME_W-1:0] t_out);
    logic [TIME_W-1:0] elapsed;
    logic [TIME_W-1:0] span;
    elapsed = now - t_in;
    span    = t_out - t_in;
    return (elapsed >= span);
  endfunction

  // Entry storage (data only; validity is tracked by pointers and level)
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [TIME_W-1:0] r_in_mem   [DEPTH];
  logic [TIME_W-1:0] r_out_mem  [DEPTH];

  // Control state
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;

  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_head_addr;
  logic [TIME_W-1:0] w_head_in;
  logic [TIME_W-1:0] w_head_out;
  logic              w_due;
  logic              w_bypass;
  logic              w_pop_acc;
  logic              w_push_acc;
  logic              w_bypass_consume;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [TIME_W-1:0] w_new_out;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == LVL_W'(DEPTH));
  assign w_head_addr = r_addr_mem[r_rd_ptr];
  assign w_head_in   = r_in_mem[r_rd_ptr];
  assign w_head_out  = r_out_mem[r_rd_ptr];
  assign w_due       = f_due(count_i, w_head_in, w_head_out);
  assign w_new_out   = count_i + TIME_W'(delay_i);

`ifdef MEM_FIFO_ZERO_DELAY_BYPASS_EN
  assign w_bypass = w_empty & push_i & (delay_i == '0) & ~stall_i;
`else
  assign w_bypass = 1'b0;
`endif

  // Head presentation: bypassed entry, stored head, or zeros when empty
  always_comb begin
    addr_o          = '0;
    head_in_time_o  = '0;
    head_out_time_o = '0;
    valid_o         = 1'b0;
    if (w_bypass) begin
      addr_o          = addr_i;
      head_in_time_o  = count_i;
      head_out_time_o = count_i;
      valid_o         = 1'b1;
    end else if (!w_empty) begin
      addr_o          = w_head_addr;
      head_in_time_o  = w_head_in;
      head_out_time_o = w_head_out;
      valid_o         = w_due;
    end
  end

  assign w_pop_acc  = pop_i & valid_o & ~stall_i;
  assign w_push_acc = push_i & ~stall_i & (~w_full | w_pop_acc);

  // A bypassed entry popped in its own cycle never touches storage.
  assign w_bypass_consume = w_bypass & w_pop_acc;
  assign w_wr_en          = w_push_acc & ~w_bypass_consume;
  assign w_rd_en          = w_pop_acc & ~w_bypass_consume;

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_wr_en) - LVL_W'(w_rd_en);
      if (push_i && !stall_i && w_full && !w_pop_acc) r_ovf <= 1'b1;
    end
  end

  // Entry storage: writes land at the tail; stale contents are harmless
  // because the pointers and level decide what is visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_addr_mem[r_wr_ptr] <= addr_i;
      r_in_mem[r_wr_ptr]   <= count_i;
      r_out_mem[r_wr_ptr]  <= w_new_out;
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = r_level;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_mem_access_timed_fifo.sv
module tb_mem_access_timed_fifo;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 16;
  localparam int DELAY_W = 10;
  localparam int TIME_W  = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                stall_i;
  logic                push_i;
  logic [ADDR_W-1:0]   addr_i;
  logic [DELAY_W-1:0]  delay_i;
  logic [TIME_W-1:0]   count_i;
  logic                pop_i;
  logic [ADDR_W-1:0]   addr_o;
  logic                valid_o;
  logic [TIME_W-1:0]   head_in_time_o;
  logic [TIME_W-1:0]   head_out_time_o;
  logic                full_o;
  logic                empty_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_timed_fifo #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .TIME_W(TIME_W)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .push_i(push_i),
    .addr_i(addr_i), .delay_i(delay_i), .count_i(count_i), .pop_i(pop_i),
    .addr_o(addr_o), .valid_o(valid_o), .head_in_time_o(head_in_time_o),
    .head_out_time_o(head_out_time_o), .full_o(full_o), .empty_o(empty_o),
    .level_o(level_o), .ovf_o(ovf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; push_i = 1'b0; pop_i = 1'b0; stall_i = 1'b0;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    addr_i = '0; delay_i = '0; count_i = '0;
    step(); step();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_level", 32'(level_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full",  32'(full_o),  0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ovf",   32'(ovf_o),   0);
    chk("rst_addr",  32'(addr_o),  0);

    // 1: reset mid-operation discards entries
    count_i = 16'd50; delay_i = 10'd5; push_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      addr_i = ADDR_W'(i);
      step();
    end
    push_i = 1'b0;
    #1;
    chk("t1_level3", 32'(level_o), 3);
    chk("t1_head_in", 32'(head_in_time_o), 50);
    do_reset();
    chk("t1_level0", 32'(level_o), 0);
    chk("t1_empty",  32'(empty_o), 1);
    chk("t1_valid",  32'(valid_o), 0);
    chk("t1_ovf",    32'(ovf_o),   0);

    // 2: timing, pop held high while head not yet due
    count_i = 16'd100; addr_i = 5'h01; delay_i = 10'd10; push_i = 1'b1; pop_i = 1'b1;
    step();
    push_i = 1'b0;
    #1;
    chk("t2_level1",   32'(level_o), 1);
    chk("t2_in_time",  32'(head_in_time_o), 100);
    chk("t2_out_time", 32'(head_out_time_o), 110);
    for (int c = 100; c < 110; c++) begin
      count_i = TIME_W'(c);
      #1;
      chk("t2_not_due", 32'(valid_o), 0);
      step();
    end
    chk("t2_level_held", 32'(level_o), 1);
    count_i = 16'd110;
    #1;
    chk("t2_due",  32'(valid_o), 1);
    chk("t2_addr", 32'(addr_o), 32'h01);
    step();
    pop_i = 1'b0;
    #1;
    chk("t2_popped", 32'(level_o), 0);
    chk("t2_empty",  32'(empty_o), 1);

    // 3: timebase wrap
    count_i = 16'hFFFA; addr_i = 5'h02; delay_i = 10'd10; push_i = 1'b1;
    step();
    push_i = 1'b0;
    #1;
    chk("t3_out_time", 32'(head_out_time_o), 32'h0004);
    count_i = 16'hFFFF; #1; chk("t3_ffff", 32'(valid_o), 0);
    count_i = 16'h0000; #1; chk("t3_0000", 32'(valid_o), 0);
    count_i = 16'h0003; #1; chk("t3_0003", 32'(valid_o), 0);
    count_i = 16'h0004; #1; chk("t3_0004", 32'(valid_o), 1);
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    #1;
    chk("t3_drained", 32'(level_o), 0);

    // 4: full, overflow, push+pop on full
    count_i = 16'h0200; delay_i = 10'd0; push_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      addr_i = ADDR_W'(i);
      step();
    end
    #1;
    chk("t4_full",   32'(full_o),  1);
    chk("t4_level",  32'(level_o), 16);
    chk("t4_noovf",  32'(ovf_o),   0);
    addr_i = 5'h11;
    step();
    #1;
    chk("t4_ovf",       32'(ovf_o),   1);
    chk("t4_level_ovf", 32'(level_o), 16);
    chk("t4_head0",     32'(addr_o),  0);
    addr_i = 5'h15; pop_i = 1'b1;
    step();
    push_i = 1'b0;
    #1;
    chk("t4_pp_level", 32'(level_o), 16);
    chk("t4_pp_head",  32'(addr_o),  1);
    for (int i = 1; i < DEPTH; i++) step();
    pop_i = 1'b0;
    #1;
    chk("t4_tail_addr", 32'(addr_o),  32'h15);
    chk("t4_tail_lvl",  32'(level_o), 1);

    // 5: stall with push and pop on a full FIFO with due head
    do_reset();
    chk("t5_ovf_clr", 32'(ovf_o), 0);
    count_i = 16'h0250; delay_i = 10'd0; push_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      addr_i = ADDR_W'(i + 3);
      step();
    end
    stall_i = 1'b1; pop_i = 1'b1; addr_i = 5'h1A;
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("t5_level", 32'(level_o), 16);
    chk("t5_ovf",   32'(ovf_o),   0);
    chk("t5_valid", 32'(valid_o), 1);
    chk("t5_head",  32'(addr_o),  3);
    stall_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    do_reset();

    // 6: zero-delay push into empty FIFO with pop
    count_i = 16'h0300; addr_i = 5'h1F; delay_i = 10'd0; push_i = 1'b1; pop_i = 1'b1;
    #1;
`ifdef MEM_FIFO_ZERO_DELAY_BYPASS_EN
    chk("t6_byp_valid", 32'(valid_o), 1);
    chk("t6_byp_addr",  32'(addr_o),  32'h1F);
    step();
    push_i = 1'b0; pop_i = 1'b0;
    #1;
    chk("t6_byp_level", 32'(level_o), 0);
    chk("t6_byp_empty", 32'(empty_o), 1);
`else
    chk("t6_valid0", 32'(valid_o), 0);
    step();
    push_i = 1'b0; pop_i = 1'b0;
    #1;
    chk("t6_level1", 32'(level_o), 1);
    chk("t6_valid1", 32'(valid_o), 1);
    chk("t6_addr",   32'(addr_o),  32'h1F);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
